// File: rtl/p3p_pkg.sv
// Shared types and constants for the SRAM arbiter slice: data word type,
// SRAM address width, FSM state encoding and a couple of index helpers.
package p3p_pkg;

    typedef logic signed [15:0] num;

    localparam int NUM_W       = 16;
    localparam int SRAM_ADDR_W = 21;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } arb_state_e;

    // Width of an index into n requesters (at least one bit).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (p + k) mod n for p, k in [0, n).
    function automatic int rr_wrap(input int p, input int k, input int n);
        return ((p + k) >= n) ? (p + k - n) : (p + k);
    endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// Client-side and controller-side signal bundle of the SRAM arbiter.
// The arbiter uses the slave modport; the clients/controller side uses master.
interface sram_arbiter_if
    import p3p_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = SRAM_ADDR_W
);
    logic [N_REQ-1:0]        req;
    logic [N_REQ-1:0]        we;
    logic [N_REQ*ADDR_W-1:0] addr;
    logic [N_REQ*NUM_W-1:0]  wdata;
    logic [N_REQ-1:0]        gnt;
    logic [N_REQ-1:0]        done;
    num                      rdata;
    logic [ADDR_W-1:0]       sram_addr;
    num                      sram_wdata;
    logic                    read_data;
    logic                    write_data;
    logic                    sram_ready;
    num                      data_in;

    modport slave (
        input  req, we, addr, wdata, sram_ready, data_in,
        output gnt, done, rdata, sram_addr, sram_wdata, read_data, write_data
    );

    modport master (
        output req, we, addr, wdata, sram_ready, data_in,
        input  gnt, done, rdata, sram_addr, sram_wdata, read_data, write_data
    );

endinterface

// File: rtl/rr_select.sv
// Combinational round-robin pick: first eligible index at or after the
// pointer, wrapping around.
module rr_select
    import p3p_pkg::*;
#(
    parameter int N  = 3,
    parameter int IW = idx_w(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] pointer,
    output logic [N-1:0]  onehot,
    output logic [IW-1:0] index,
    output logic          valid
);
    logic [IW-1:0] pos_s;
    logic          take_s;

    // Scan from the pointer outward; the first hit locks out later candidates.
    always_comb begin
        onehot = '0;
        index  = '0;
        valid  = 1'b0;
        pos_s  = '0;
        take_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos_s         = IW'(rr_wrap(int'(pointer), k, N));
            take_s        = ~valid & eligible[pos_s];
            onehot[pos_s] = take_s;
            index         = take_s ? pos_s : index;
            valid         = valid | take_s;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller port between N_REQ clients,
// one transaction at a time: IDLE -> ISSUE (strobe) -> WAIT (completion).
module sram_arbiter
    import p3p_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = SRAM_ADDR_W
) (
    input  logic          clk,
    input  logic          reset,
    sram_arbiter_if.slave bus
);
    localparam int IW = idx_w(N_REQ);

    arb_state_e        state_r;
    arb_state_e        state_nxt_s;
    logic [IW-1:0]     ptr_r;
    logic [IW-1:0]     win_idx_r;
    logic [IW-1:0]     sel_idx_s;
    logic [N_REQ-1:0]  eligible_s;
    logic [N_REQ-1:0]  sel_onehot_s;
    logic [N_REQ-1:0]  gnt_r;
    logic [N_REQ-1:0]  done_r;
    logic              sel_valid_s;
    logic              sel_we_s;
    logic              grant_s;
    logic              complete_s;
    logic              we_r;
    logic              rd_stb_r;
    logic              wr_stb_r;
    logic [ADDR_W-1:0] addr_r;
    num                wdata_r;
    num                rdata_r;

    // A client finishing this cycle must not win again until its done pulse is gone.
    assign eligible_s = bus.req & ~done_r;

    rr_select #(.N(N_REQ), .IW(IW)) u_rr_select (
        .eligible (eligible_s),
        .pointer  (ptr_r),
        .onehot   (sel_onehot_s),
        .index    (sel_idx_s),
        .valid    (sel_valid_s)
    );

    assign sel_we_s   = bus.we[sel_idx_s];
    assign grant_s    = (state_r == IDLE) & sel_valid_s & bus.sram_ready;
    assign complete_s = (state_r == WAIT) & bus.sram_ready;

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE:    state_nxt_s = grant_s ? ISSUE : IDLE;
            ISSUE:   state_nxt_s = WAIT;
            WAIT:    state_nxt_s = complete_s ? IDLE : WAIT;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command latch, strobes, grant/done, pointer and read-data registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_stb_r  <= 1'b0;
            wr_stb_r  <= 1'b0;
            gnt_r     <= '0;
            done_r    <= '0;
            win_idx_r <= '0;
            ptr_r     <= '0;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= 16'sd0;
            rdata_r   <= 16'sd0;
        end else begin
            // Strobes are set on the grant edge so they are high exactly during ISSUE.
            rd_stb_r <= grant_s & ~sel_we_s;
            wr_stb_r <= grant_s & sel_we_s;
            done_r   <= complete_s ? gnt_r : '0;
            if (grant_s) begin
                gnt_r     <= sel_onehot_s;
                win_idx_r <= sel_idx_s;
                we_r      <= sel_we_s;
                addr_r    <= bus.addr[int'(sel_idx_s)*ADDR_W +: ADDR_W];
                wdata_r   <= bus.wdata[int'(sel_idx_s)*NUM_W +: NUM_W];
            end else if (complete_s) begin
                gnt_r <= '0;
            end else begin
                gnt_r <= gnt_r;
            end
            if (state_r == ISSUE) begin
                ptr_r <= (win_idx_r == IW'(N_REQ - 1)) ? '0 : win_idx_r + IW'(1);
            end else begin
                ptr_r <= ptr_r;
            end
            if (complete_s && !we_r) begin
                rdata_r <= bus.data_in;
            end else begin
                rdata_r <= rdata_r;
            end
        end
    end

    assign bus.gnt        = gnt_r;
    assign bus.done       = done_r;
    assign bus.rdata      = rdata_r;
    assign bus.sram_addr  = addr_r;
    assign bus.sram_wdata = wdata_r;
    assign bus.read_data  = rd_stb_r;
    assign bus.write_data = wr_stb_r;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed self-checking bench for sram_arbiter with three clients.
module tb_sram_arbiter;
    import p3p_pkg::*;

    logic clk;
    logic reset;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    sram_arbiter_if #(.N_REQ(3), .ADDR_W(21)) bus ();

    sram_arbiter #(.N_REQ(3), .ADDR_W(21)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_client(input int c, input logic w, input logic [20:0] a, input logic [15:0] d);
        bus.we[c]              = w;
        bus.addr[c*21 +: 21]   = a;
        bus.wdata[c*16 +: 16]  = d;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        bus.req        = 3'b000;
        bus.we         = 3'b000;
        bus.addr       = '0;
        bus.wdata      = '0;
        bus.sram_ready = 1'b1;
        bus.data_in    = 16'sd0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_gnt(output logic [2:0] g, output int n);
        g = 3'b000;
        n = 0;
        while (g == 3'b000 && n < 20) begin
            step();
            n++;
            g = bus.gnt;
        end
    endtask

    task automatic wait_done(output logic [2:0] d, output int n);
        d = 3'b000;
        n = 0;
        while (d == 3'b000 && n < 20) begin
            step();
            n++;
            d = bus.done;
        end
    endtask

    task automatic test_reset();
        do_reset();
        reset   = 1'b1;
        bus.req = 3'b111;
        step();
        step();
        vec_cnt++;
        if ({bus.gnt, bus.done, bus.read_data, bus.write_data} !== 8'h00) begin
            err_cnt++;
            $display("FAIL reset_ctl: gnt=%b done=%b rd=%b wr=%b, all required 0",
                     bus.gnt, bus.done, bus.read_data, bus.write_data);
        end
        vec_cnt++;
        if ({bus.rdata, bus.sram_wdata, bus.sram_addr} !== 53'd0) begin
            err_cnt++;
            $display("FAIL reset_data: rdata=%h wdata=%h addr=%h, all required 0",
                     bus.rdata, bus.sram_wdata, bus.sram_addr);
        end
        bus.req = 3'b000;
        reset   = 1'b0;
    endtask

    task automatic test_single_read();
        set_client(0, 1'b0, 21'h00010, 16'h0000);
        bus.data_in    = 16'sh55aa;
        bus.sram_ready = 1'b1;
        bus.req        = 3'b001;
        step();
        vec_cnt++;
        if ({bus.read_data, bus.write_data, bus.gnt} !== 5'b10001) begin
            err_cnt++;
            $display("FAIL t1_strobe: rd=%b wr=%b gnt=%b, required rd=1 wr=0 gnt=001",
                     bus.read_data, bus.write_data, bus.gnt);
        end
        vec_cnt++;
        if (bus.sram_addr !== 21'h00010) begin
            err_cnt++;
            $display("FAIL t1_addr: sram_addr=%h required 00010", bus.sram_addr);
        end
        step();
        vec_cnt++;
        if ({bus.read_data, bus.done} !== 4'b0000) begin
            err_cnt++;
            $display("FAIL t1_wait: rd=%b done=%b required 0/000", bus.read_data, bus.done);
        end
        step();
        vec_cnt++;
        if ({bus.done, bus.gnt} !== 6'b001000) begin
            err_cnt++;
            $display("FAIL t1_done: done=%b gnt=%b required 001/000", bus.done, bus.gnt);
        end
        vec_cnt++;
        if (bus.rdata !== 16'sh55aa) begin
            err_cnt++;
            $display("FAIL t1_rdata: rdata=%h required 55aa", bus.rdata);
        end
        bus.req = 3'b000;
        step();
        vec_cnt++;
        if (bus.done !== 3'b000) begin
            err_cnt++;
            $display("FAIL t1_pulse: done=%b required 000", bus.done);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] g;
        logic [2:0] d;
        int         n;
        do_reset();
        bus.data_in = 16'sh55aa;
        bus.req     = 3'b111;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 3; k++) begin
                wait_gnt(g, n);
                vec_cnt++;
                if (g !== (3'b001 << k)) begin
                    err_cnt++;
                    $display("FAIL rr_gnt r%0d k%0d: gnt=%b required %b", r, k, g, 3'b001 << k);
                end
                wait_done(d, n);
                vec_cnt++;
                if (d !== g) begin
                    err_cnt++;
                    $display("FAIL rr_done r%0d k%0d: done=%b required %b", r, k, d, g);
                end
                bus.req = bus.req & ~d;
            end
            bus.req = 3'b111;
        end
        bus.req = 3'b000;
        step();
    endtask

    task automatic test_write();
        logic [2:0] d;
        int         n;
        set_client(1, 1'b1, 21'h1FFFFF, 16'h8000);
        bus.data_in = 16'sh1234;
        bus.req     = 3'b010;
        step();
        vec_cnt++;
        if ({bus.write_data, bus.read_data, bus.gnt} !== 5'b10010) begin
            err_cnt++;
            $display("FAIL t3_strobe: wr=%b rd=%b gnt=%b required 1/0/010",
                     bus.write_data, bus.read_data, bus.gnt);
        end
        vec_cnt++;
        if ({bus.sram_addr, bus.sram_wdata} !== {21'h1FFFFF, 16'h8000}) begin
            err_cnt++;
            $display("FAIL t3_cmd: addr=%h wdata=%h required 1fffff/8000", bus.sram_addr, bus.sram_wdata);
        end
        set_client(1, 1'b1, 21'h000000, 16'h0001);
        wait_done(d, n);
        vec_cnt++;
        if (d !== 3'b010 || n !== 2) begin
            err_cnt++;
            $display("FAIL t3_done: done=%b after %0d cycles, required 010 after 2", d, n);
        end
        vec_cnt++;
        if ({bus.rdata, bus.sram_addr} !== {16'h55aa, 21'h1FFFFF}) begin
            err_cnt++;
            $display("FAIL t3_hold: rdata=%h addr=%h required 55aa/1fffff", bus.rdata, bus.sram_addr);
        end
        bus.req = 3'b000;
        bus.we  = 3'b000;
        step();
    endtask

    task automatic test_slow_sram();
        logic [2:0] d;
        int         n;
        set_client(0, 1'b0, 21'h00123, 16'h0000);
        bus.req = 3'b001;
        step();
        vec_cnt++;
        if (bus.read_data !== 1'b1) begin
            err_cnt++;
            $display("FAIL t4_strobe: rd=%b required 1", bus.read_data);
        end
        bus.sram_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            vec_cnt++;
            if ({bus.gnt, bus.read_data, bus.write_data, bus.done} !== 8'b00100000) begin
                err_cnt++;
                $display("FAIL t4_busy c%0d: gnt=%b rd=%b wr=%b done=%b required 001/0/0/000",
                         i, bus.gnt, bus.read_data, bus.write_data, bus.done);
            end
        end
        bus.sram_ready = 1'b1;
        bus.data_in    = 16'shbeef;
        wait_done(d, n);
        vec_cnt++;
        if (d !== 3'b001 || n !== 1 || bus.rdata !== 16'shbeef) begin
            err_cnt++;
            $display("FAIL t4_done: done=%b after %0d rdata=%h, required 001 after 1 rdata=beef",
                     d, n, bus.rdata);
        end
        bus.req = 3'b000;
        step();
    endtask

    task automatic test_reset_in_wait();
        logic [2:0] g;
        logic [2:0] d;
        int         n;
        set_client(1, 1'b0, 21'h00077, 16'h0000);
        set_client(2, 1'b0, 21'h00200, 16'h0000);
        bus.req = 3'b010;
        wait_gnt(g, n);
        bus.sram_ready = 1'b0;
        step();
        step();
        reset   = 1'b1;
        bus.req = 3'b000;
        step();
        vec_cnt++;
        if ({bus.gnt, bus.done, bus.read_data, bus.write_data, bus.rdata, bus.sram_addr} !== 45'd0) begin
            err_cnt++;
            $display("FAIL t5_reset: gnt=%b done=%b rd=%b wr=%b rdata=%h addr=%h, all required 0",
                     bus.gnt, bus.done, bus.read_data, bus.write_data, bus.rdata, bus.sram_addr);
        end
        reset          = 1'b0;
        bus.sram_ready = 1'b1;
        bus.req        = 3'b100;
        wait_gnt(g, n);
        vec_cnt++;
        if (g !== 3'b100 || n !== 1 || bus.sram_addr !== 21'h00200) begin
            err_cnt++;
            $display("FAIL t5_wrap: gnt=%b after %0d addr=%h, required 100 after 1 addr=00200",
                     g, n, bus.sram_addr);
        end
        wait_done(d, n);
        vec_cnt++;
        if (d !== 3'b100) begin
            err_cnt++;
            $display("FAIL t5_done: done=%b required 100", d);
        end
        bus.req = 3'b000;
        step();
    endtask

    task automatic test_back_to_back();
        logic [2:0] g;
        logic [2:0] d;
        int         n;
        bus.req = 3'b011;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(g, n);
            vec_cnt++;
            if (g !== ((k % 2 == 0) ? 3'b001 : 3'b010) || n !== 1) begin
                err_cnt++;
                $display("FAIL b2b_gnt k%0d: gnt=%b after %0d, required %b after 1",
                         k, g, n, (k % 2 == 0) ? 3'b001 : 3'b010);
            end
            wait_done(d, n);
        end
        // Client 0 alone: it sits out its own done cycle, so regrant takes two cycles.
        bus.req = 3'b001;
        wait_gnt(g, n);
        wait_done(d, n);
        wait_gnt(g, n);
        vec_cnt++;
        if (g !== 3'b001 || n !== 2) begin
            err_cnt++;
            $display("FAIL b2b_excl: gnt=%b after %0d, required 001 after 2", g, n);
        end
        wait_done(d, n);
        bus.req = 3'b000;
        step();
    endtask

    initial begin
        reset          = 1'b1;
        bus.req        = 3'b000;
        bus.we         = 3'b000;
        bus.addr       = '0;
        bus.wdata      = '0;
        bus.sram_ready = 1'b1;
        bus.data_in    = 16'sd0;
        test_reset();
        test_single_read();
        test_round_robin();
        test_write();
        test_slow_sram();
        test_reset_in_wait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
